pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Owns the architectural program counter and drives instruction fetch. It consumes the 2-bit `pc_sel` produced by the branch control unit and commits the next PC when the core retires an instruction: sequential, branch/JAL target, JALR target, or system (ECALL trap / EBREAK halt). It sits between instruction memory and the decode stage, and is the only writer of `pc` and `epc`.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset
- `TRAP_VEC`, 32'h0000_0100, PC loaded on ECALL (and on misaligned target when enabled)
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `pc_sel`  in  2  next-PC select: 00 pc+4, 01 branch_target, 10 jalr_target, 11 system
- `branch_target`  in  32  pc+imm from the core adder (branch/JAL)
- `jalr_target`  in  32  ALU result for JALR
- `sys_ebreak`  in  1  qualifies `pc_sel`=11: 1 EBREAK, 0 ECALL
- `commit`  in  1  current instruction finished; apply `pc_sel` this cycle
- `stall`  in  1  hold everything; overrides `commit`
- `dbg_resume`  in  1  leave HALT
- `imem_req`  out  1  fetch request, address `pc`
- `imem_ack`  in  1  `imem_rdata` valid this cycle
- `imem_rdata`  in  32  fetched word
- `instr`  out  32  latched instruction for decode
- `instr_valid`  out  1  `instr` valid, high throughout EXEC
- `pc`  out  32  current PC
- `pc_plus4`  out  32  pc+4 (JAL/JALR link value)
- `epc`  out  32  PC of last trapping instruction
- `trap_taken`  out  1  one-cycle pulse on trap entry
- `halted`  out  1  high in HALT

## Operation
- States: IDLE, FETCH, EXEC, TRAP, HALT. Reset → IDLE.
- IDLE: one cycle, → FETCH.
- FETCH: `imem_req`=1. On `imem_ack`: `instr`<=`imem_rdata`, → EXEC. `imem_ack` ignored in every other state.
- EXEC: `instr_valid`=1. `stall`=1 → hold. `commit`=1 and `stall`=0:
  - 00: pc<=pc+4, → FETCH
  - 01: pc<=branch_target, → FETCH
  - 10: pc<={jalr_target[31:1],1'b0}, → FETCH
  - 11, `sys_ebreak`=0: epc<=pc, → TRAP
  - 11, `sys_ebreak`=1: → HALT, pc unchanged
- TRAP: one cycle. `trap_taken`=1, pc<=TRAP_VEC, → FETCH.
- HALT: `halted`=1, no fetch. `dbg_resume` → pc<=pc+4, → FETCH.
- Arithmetic: 32-bit modulo; pc+4 from 32'hFFFF_FFFC wraps to 0. `pc_plus4` is combinational from `pc`.
- `rst` overrides everything in every state, including mid-fetch, where an outstanding ack is dropped.

## Timing
- Reset values: pc=RESET_PC, epc=0, instr=0, instr_valid=0, imem_req=0, trap_taken=0, halted=0.
- `imem_req` first rises in the cycle after the IDLE cycle, i.e. the second cycle after `rst` falls.
- `imem_req` is a Moore output and stays high until the ack cycle inclusive. Memory may take any number of cycles.
- Minimum instruction cycle: FETCH (ack same cycle) + EXEC (commit same cycle) = 2 cycles. ECALL adds 1 cycle for TRAP.
- `pc` updates on the edge ending the commit cycle (TRAP cycle for traps). `instr_valid` falls on that same edge.
- `stall` and `commit` both high: no state change, commit lost. The core must hold `commit`.

## Configuration
- `MISALIGN_TRAP_EN` defined: a commit whose selected target (01 or 10, after bit-0 clear) has bit 1 set goes to TRAP with epc<=pc instead of jumping.
- `MISALIGN_TRAP_EN` undefined: bits [1:0] of every target are forced to 0 and there are no misalignment traps.

## Structure
- defines.v gains:
  - `PC_SEL_SEQ`/`PC_SEL_BR`/`PC_SEL_JALR`/`PC_SEL_SYS` (2'b00..2'b11), shared with the branch control unit
  - state codes `PCS_IDLE`..`PCS_HALT`
- One sub-module, `pc_next_mux`: combinational target select plus alignment (and the misalign flag under the macro). The FSM and registers stay in `pc_sequencer`.

## Test plan
- Reset, release, ack on first FETCH cycle with rdata 32'h0000_0013, commit with 00 → imem_req first high at cycle 2; instr=32'h13; pc 0→4.
- pc=0x40, commit 01 with branch_target 0x20 → pc=0x20 next cycle. commit 10 with jalr_target 0x105 → pc=0x104.
- pc=0x80, commit 11 with sys_ebreak=0 → TRAP cycle with trap_taken=1; then epc=0x80, pc=0x100, next state FETCH.
- pc=0x90, commit 11 with sys_ebreak=1 → halted=1, imem_req=0 for 10 cycles; dbg_resume → pc=0x94, fetch resumes.
- stall and commit both high for 3 cycles, then commit alone → pc changes only after the stall drops; imem_ack pulsed during EXEC is ignored.
- pc=32'hFFFF_FFFC, commit 00 → pc=0. rst asserted while waiting for ack in FETCH → pc=RESET_PC, imem_req low the following cycle. With MISALIGN_TRAP_EN, branch_target 0x22 → trap, epc=pc.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the PC sequencer: next-PC select codes (also used by
// the branch control unit) and sequencer state codes.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        PC_SEL_SEQ  = 2'b00,
        PC_SEL_BR   = 2'b01,
        PC_SEL_JALR = 2'b10,
        PC_SEL_SYS  = 2'b11
    } pc_sel_e;

    typedef enum logic [2:0] {
        PCS_IDLE  = 3'd0,
        PCS_FETCH = 3'd1,
        PCS_EXEC  = 3'd2,
        PCS_TRAP  = 3'd3,
        PCS_HALT  = 3'd4
    } pcs_state_e;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/pc_sequencer_pc_next_mux.sv
// Combinational next-PC target select with word alignment.
// With MISALIGN_TRAP_EN defined, flags branch/JALR targets whose bit 1 is set.
module pc_next_mux
    import pc_sequencer_pkg::*;
(
    input  logic [1:0]  pc_sel,
    input  logic [31:0] pc,
    input  logic [31:0] branch_target,
    input  logic [31:0] jalr_target,
    output logic [31:0] target,
    output logic        misalign
);

    logic [31:0] raw;

    always_comb begin
        raw = pc + PC_STEP;
        case (pc_sel)
            PC_SEL_BR:   raw = branch_target;
            PC_SEL_JALR: raw = {jalr_target[31:1], 1'b0};
            default:     raw = pc + PC_STEP;
        endcase
        target   = raw & ~32'd3;
        misalign = 1'b0;
`ifdef MISALIGN_TRAP_EN
        // bit 1 is checked after JALR's bit-0 clear; the jump is replaced by a trap
        misalign = ((pc_sel == PC_SEL_BR) || (pc_sel == PC_SEL_JALR)) && raw[1];
`endif
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner and fetch sequencer (IDLE/FETCH/EXEC/TRAP/HALT).
// Optional MISALIGN_TRAP_EN turns misaligned branch/JALR targets into traps.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  pc_sel,
    input  logic [31:0] branch_target,
    input  logic [31:0] jalr_target,
    input  logic        sys_ebreak,
    input  logic        commit,
    input  logic        stall,
    input  logic        dbg_resume,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] epc,
    output logic        trap_taken,
    output logic        halted
);

    pcs_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] instr_q, instr_d;
    logic        imem_req_q, instr_valid_q, trap_taken_q, halted_q;
    logic [31:0] target;
    logic        misalign;

    pc_next_mux u_next (
        .pc_sel        (pc_sel),
        .pc            (pc_q),
        .branch_target (branch_target),
        .jalr_target   (jalr_target),
        .target        (target),
        .misalign      (misalign)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        instr_d = instr_q;
        case (state_q)
            PCS_IDLE: state_d = PCS_FETCH;
            PCS_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = PCS_EXEC;
                end
            end
            PCS_EXEC: begin
                // stall wins over commit; a commit raised under stall is simply not taken
                if (commit && !stall) begin
                    if (pc_sel == PC_SEL_SYS) begin
                        if (sys_ebreak) begin
                            state_d = PCS_HALT;
                        end else begin
                            epc_d   = pc_q;
                            state_d = PCS_TRAP;
                        end
                    end else if (misalign) begin
                        epc_d   = pc_q;
                        state_d = PCS_TRAP;
                    end else begin
                        pc_d    = target;
                        state_d = PCS_FETCH;
                    end
                end
            end
            PCS_TRAP: begin
                pc_d    = TRAP_VEC;
                state_d = PCS_FETCH;
            end
            PCS_HALT: begin
                if (dbg_resume) begin
                    pc_d    = pc_q + PC_STEP;
                    state_d = PCS_FETCH;
                end
            end
            default: state_d = PCS_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= PCS_IDLE;
            pc_q          <= RESET_PC;
            epc_q         <= 32'd0;
            instr_q       <= 32'd0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            trap_taken_q  <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            epc_q         <= epc_d;
            instr_q       <= instr_d;
            imem_req_q    <= (state_d == PCS_FETCH);
            instr_valid_q <= (state_d == PCS_EXEC);
            trap_taken_q  <= (state_d == PCS_TRAP);
            halted_q      <= (state_d == PCS_HALT);
        end
    end

    assign pc          = pc_q;
    assign pc_plus4    = pc_q + PC_STEP;
    assign epc         = epc_q;
    assign instr       = instr_q;
    assign imem_req    = imem_req_q;
    assign instr_valid = instr_valid_q;
    assign trap_taken  = trap_taken_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: fetch/commit paths, trap, halt, stall,
// wrap-around and reset during fetch.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  pc_sel;
    logic [31:0] branch_target;
    logic [31:0] jalr_target;
    logic        sys_ebreak;
    logic        commit;
    logic        stall;
    logic        dbg_resume;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] epc;
    logic        trap_taken;
    logic        halted;

    int n_tests = 0;
    int n_fail  = 0;

    pc_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .pc_sel        (pc_sel),
        .branch_target (branch_target),
        .jalr_target   (jalr_target),
        .sys_ebreak    (sys_ebreak),
        .commit        (commit),
        .stall         (stall),
        .dbg_resume    (dbg_resume),
        .imem_req      (imem_req),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .epc           (epc),
        .trap_taken    (trap_taken),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // one rising edge, then land mid-cycle for sampling and driving
    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_fetch(input logic [31:0] word);
        int n = 0;
        while (!imem_req && n < 20) begin
            step();
            n++;
        end
        chk("fetch_req", 32'(imem_req), 32'd1);
        imem_ack   = 1'b1;
        imem_rdata = word;
        step();
        imem_ack   = 1'b0;
        chk("fetch_valid", 32'(instr_valid), 32'd1);
    endtask

    task automatic do_commit(input logic [1:0] sel, input logic [31:0] bt,
                             input logic [31:0] jt, input logic eb);
        pc_sel        = sel;
        branch_target = bt;
        jalr_target   = jt;
        sys_ebreak    = eb;
        commit        = 1'b1;
        step();
        commit        = 1'b0;
    endtask

    initial begin
        int cyc;
        int bad_req;
        rst = 1'b1; pc_sel = 2'b00; branch_target = 32'd0; jalr_target = 32'd0;
        sys_ebreak = 1'b0; commit = 1'b0; stall = 1'b0; dbg_resume = 1'b0;
        imem_ack = 1'b0; imem_rdata = 32'd0;
        step(); step();

        chk("rst_pc", pc, 32'h0);
        chk("rst_epc", epc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_trap", 32'(trap_taken), 32'd0);
        chk("rst_halt", 32'(halted), 32'd0);

        // release: IDLE this cycle, FETCH after the next edge
        rst = 1'b0;
        cyc = 0;
        while (!imem_req && cyc < 10) begin
            step();
            cyc++;
        end
        chk("req_latency", 32'(cyc), 32'd1);
        do_fetch(32'h0000_0013);
        chk("instr_13", instr, 32'h0000_0013);
        chk("pc_before", pc, 32'h0);
        chk("pc_plus4_0", pc_plus4, 32'h4);
        do_commit(2'b00, 32'h0, 32'h0, 1'b0);
        chk("seq_pc", pc, 32'h4);
        chk("seq_valid_drop", 32'(instr_valid), 32'd0);
        chk("seq_req", 32'(imem_req), 32'd1);

        // branch and JALR
        do_fetch(32'h1); do_commit(2'b01, 32'h40, 32'h0, 1'b0);
        chk("br_40", pc, 32'h40);
        do_fetch(32'h2); do_commit(2'b01, 32'h20, 32'h0, 1'b0);
        chk("br_20", pc, 32'h20);
        do_fetch(32'h3); do_commit(2'b10, 32'h0, 32'h105, 1'b0);
        chk("jalr_104", pc, 32'h104);

        // ECALL at 0x80
        do_fetch(32'h4); do_commit(2'b01, 32'h80, 32'h0, 1'b0);
        do_fetch(32'h73); do_commit(2'b11, 32'h0, 32'h0, 1'b0);
        chk("ecall_trap", 32'(trap_taken), 32'd1);
        chk("ecall_epc", epc, 32'h80);
        chk("ecall_pc_hold", pc, 32'h80);
        chk("ecall_noreq", 32'(imem_req), 32'd0);
        step();
        chk("trap_pulse_end", 32'(trap_taken), 32'd0);
        chk("trap_vec", pc, 32'h100);
        chk("trap_fetch", 32'(imem_req), 32'd1);

        // EBREAK at 0x90, halt for 10 cycles, then resume
        do_fetch(32'h5); do_commit(2'b01, 32'h90, 32'h0, 1'b0);
        do_fetch(32'h0010_0073); do_commit(2'b11, 32'h0, 32'h0, 1'b1);
        chk("halted", 32'(halted), 32'd1);
        bad_req = 0;
        for (int i = 0; i < 10; i++) begin
            if (imem_req || !halted || pc != 32'h90) bad_req++;
            step();
        end
        chk("halt_quiet", 32'(bad_req), 32'd0);
        dbg_resume = 1'b1;
        step();
        dbg_resume = 1'b0;
        chk("resume_pc", pc, 32'h94);
        chk("resume_halt", 32'(halted), 32'd0);
        chk("resume_req", 32'(imem_req), 32'd1);

        // stall overrides commit; ack during EXEC ignored
        do_fetch(32'hAAAA_0001);
        pc_sel = 2'b00; commit = 1'b1; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            imem_ack   = (i == 1);
            imem_rdata = 32'hDEAD_BEEF;
            step();
        end
        imem_ack = 1'b0;
        chk("stall_pc", pc, 32'h94);
        chk("stall_valid", 32'(instr_valid), 32'd1);
        chk("stall_instr", instr, 32'hAAAA_0001);
        stall = 1'b0;
        step();
        commit = 1'b0;
        chk("stall_release", pc, 32'h98);

        // wrap-around
        do_fetch(32'h6); do_commit(2'b01, 32'hFFFF_FFFC, 32'h0, 1'b0);
        chk("top_pc", pc, 32'hFFFF_FFFC);
        chk("top_plus4", pc_plus4, 32'h0);
        do_fetch(32'h7); do_commit(2'b00, 32'h0, 32'h0, 1'b0);
        chk("wrap_pc", pc, 32'h0);

        // reset during an outstanding fetch, with ack coinciding with reset
        do_fetch(32'h8); do_commit(2'b01, 32'h200, 32'h0, 1'b0);
        step(); step();
        chk("wait_req", 32'(imem_req), 32'd1);
        rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h5555_5555;
        step();
        rst = 1'b0; imem_ack = 1'b0;
        chk("mid_rst_pc", pc, 32'h0);
        chk("mid_rst_req", 32'(imem_req), 32'd0);
        chk("mid_rst_instr", instr, 32'h0);
        chk("mid_rst_valid", 32'(instr_valid), 32'd0);

        // target with bit 1 set
        do_fetch(32'h9); do_commit(2'b01, 32'h44, 32'h0, 1'b0);
        do_fetch(32'hA); do_commit(2'b01, 32'h22, 32'h0, 1'b0);
`ifdef MISALIGN_TRAP_EN
        chk("mis_trap", 32'(trap_taken), 32'd1);
        chk("mis_epc", epc, 32'h44);
        step();
        chk("mis_vec", pc, 32'h100);
`else
        chk("align_pc", pc, 32'h20);
        chk("align_notrap", 32'(trap_taken), 32'd0);
        chk("align_epc", epc, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
